window_3x3_former: RTL

WINDOW_3X3_FORMER -- requirements
Module: window_3x3_former

---
 rtl/window_3x3_former.sv | 122 ++++++++++++
 1 files changed

// File: rtl/window_3x3_former.sv
// 3x3 window former: turns a stream of three-pixel column beats into zero-padded
// 3x3 neighbourhoods tagged with their centre row and column.
module window_3x3_former #(
    parameter int DATA_WIDTH = 8,
    parameter int LINE_WORDS = 10,
    parameter int LINE_COUNT = 8
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 sof,
    input  logic                                 tap_valid,
    input  logic [DATA_WIDTH-1:0]                tap_top,
    input  logic [DATA_WIDTH-1:0]                tap_mid,
    input  logic [DATA_WIDTH-1:0]                tap_bot,
    output logic [9*DATA_WIDTH-1:0]              win_data,
    output logic                                 win_valid,
    output logic [$clog2(LINE_COUNT)-1:0]        win_row,
    output logic [$clog2(LINE_WORDS)-1:0]        win_col,
    output logic                                 frame_done
);

    localparam int ROW_W = $clog2(LINE_COUNT);
    localparam int COL_W = $clog2(LINE_WORDS);
    localparam int CW    = 3 * DATA_WIDTH;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(LINE_COUNT - 1);
    localparam logic [COL_W-1:0] LAST_COL = COL_W'(LINE_WORDS - 1);

    typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;

    state_t           state;
    logic [CW-1:0]    col_l, col_c, col_r;
    logic [ROW_W-1:0] in_row, drain_row;
    logic [COL_W-1:0] in_col;
    logic [CW-1:0]    beat;

    // column words keep the top pixel in the low bits, matching win_data row order
    assign beat = {tap_bot, tap_mid, tap_top};

    function automatic logic [9*DATA_WIDTH-1:0] form_window(
        input logic [CW-1:0] left,
        input logic [CW-1:0] centre,
        input logic [CW-1:0] right,
        input logic          pad_top,
        input logic          pad_bot,
        input logic          pad_left,
        input logic          pad_right
    );
        logic [CW-1:0] cols [3];
        form_window = '0;
        cols[0] = pad_left  ? '0 : left;
        cols[1] = centre;
        cols[2] = pad_right ? '0 : right;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                if (!(r == 0 && pad_top) && !(r == 2 && pad_bot))
                    form_window[DATA_WIDTH*(3*r+c) +: DATA_WIDTH] = cols[c][DATA_WIDTH*r +: DATA_WIDTH];
            end
        end
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= FILL;
            col_l      <= '0;
            col_c      <= '0;
            col_r      <= '0;
            in_row     <= '0;
            in_col     <= '0;
            drain_row  <= '0;
            win_data   <= '0;
            win_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (sof) begin
                // a pending drain window is dropped; a same-cycle beat starts the new frame
                col_l  <= '0;
                col_c  <= '0;
                col_r  <= tap_valid ? beat : '0;
                in_row <= '0;
                in_col <= tap_valid ? COL_W'(1) : '0;
                state  <= tap_valid ? RUN : FILL;
            end else begin
                if (state == DRAIN) begin
                    win_valid  <= 1'b1;
                    win_data   <= form_window(col_c, col_r, '0, drain_row == '0,
                                              drain_row == LAST_ROW, 1'b0, 1'b1);
                    win_row    <= drain_row;
                    win_col    <= LAST_COL;
                    frame_done <= (drain_row == LAST_ROW);
                end
                if (tap_valid) begin
                    col_l <= col_c;
                    col_c <= col_r;
                    col_r <= beat;
                    if (in_col != '0) begin
                        win_valid <= 1'b1;
                        win_data  <= form_window(col_c, col_r, beat, in_row == '0,
                                                 in_row == LAST_ROW, in_col == COL_W'(1), 1'b0);
                        win_row   <= in_row;
                        win_col   <= in_col - COL_W'(1);
                    end
                    if (in_col == LAST_COL) begin
                        in_col    <= '0;
                        in_row    <= (in_row == LAST_ROW) ? '0 : in_row + ROW_W'(1);
                        drain_row <= in_row;
                        state     <= DRAIN;
                    end else begin
                        in_col <= in_col + COL_W'(1);
                        state  <= RUN;
                    end
                end else if (state == DRAIN) begin
                    state <= FILL;
                end
            end
        end
    end

endmodule
